// File: rtl/pipeline_result_combiner.sv
// rtl/pipeline_result_combiner.sv - per-channel result capture, registered adder-tree reduction, output FIFO
// Credits cover tree stages plus FIFO entries, so the tree never has to stall.
module pipeline_result_combiner #(
   parameter int NUM_CHANNELS       = 4,
   parameter int SUM_WIDTH          = 48,
   parameter int COUNT_WIDTH        = 13,
   parameter int FIFO_DEPTH_LOG2    = 4,
   parameter int ALMOST_FULL_MARGIN = 4,
   localparam int L                 = $clog2(NUM_CHANNELS)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_CHANNELS-1:0]             chanValid,
   input  logic [NUM_CHANNELS*SUM_WIDTH-1:0]   chanSum,
   input  logic [NUM_CHANNELS*COUNT_WIDTH-1:0] chanCount,
   output logic [NUM_CHANNELS-1:0]             chanGrab,
   output logic                                outValid,
   output logic [SUM_WIDTH+L-1:0]              outSum,
   output logic [COUNT_WIDTH+L-1:0]            outCount,
   input  logic                                outGrab,
   output logic                                slowDown,
   output logic [31:0]                         batchCount
);

   localparam int TSW   = SUM_WIDTH + L;
   localparam int TCW   = COUNT_WIDTH + L;
   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int HALF  = NUM_CHANNELS / 2;
   localparam int OW    = FIFO_DEPTH_LOG2 + 1;

   logic [NUM_CHANNELS-1:0]    full;
   logic [SUM_WIDTH-1:0]       slot_sum [NUM_CHANNELS];
   logic [COUNT_WIDTH-1:0]     slot_cnt [NUM_CHANNELS];
   logic [L-1:0]               tree_valid;
   logic [TSW-1:0]             tree_sum [L][HALF];
   logic [TCW-1:0]             tree_cnt [L][HALF];
   logic [TSW-1:0]             fifo_sum [DEPTH];
   logic [TCW-1:0]             fifo_cnt [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
   logic [OW-1:0]              fifo_level;
   logic [OW-1:0]              occupancy;
   logic [OW-1:0]              occupancy_next;
   logic                       launch;
   logic                       pop;
   logic                       fifo_write;
   logic                       almost_full;

   assign launch         = (&full) && (occupancy < OW'(DEPTH));
   assign chanGrab       = ~full | {NUM_CHANNELS{launch}};
   assign outValid       = (fifo_level != '0);
   assign pop            = outValid & outGrab;
   assign fifo_write     = tree_valid[L-1];
   assign occupancy_next = occupancy + OW'(launch) - OW'(pop);
   assign almost_full    = (DEPTH - int'(occupancy_next)) <= ALMOST_FULL_MARGIN;
   assign outSum         = outValid ? fifo_sum[rd_ptr] : '0;
   assign outCount       = outValid ? fifo_cnt[rd_ptr] : '0;

   // A slot refilled on its launch edge stays full with the new value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= '0;
      end else begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (chanValid[i] && chanGrab[i]) begin
               full[i] <= 1'b1;
            end else if (launch) begin
               full[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (chanValid[i] && chanGrab[i]) begin
            slot_sum[i] <= chanSum[i*SUM_WIDTH +: SUM_WIDTH];
            slot_cnt[i] <= chanCount[i*COUNT_WIDTH +: COUNT_WIDTH];
         end
      end
   end

   // Operands are zero-extended to the final width, so no stage can overflow.
   always_ff @(posedge clk) begin
      for (int j = 0; j < HALF; j++) begin
         tree_sum[0][j] <= TSW'(slot_sum[2*j]) + TSW'(slot_sum[2*j+1]);
         tree_cnt[0][j] <= TCW'(slot_cnt[2*j]) + TCW'(slot_cnt[2*j+1]);
      end
      for (int k = 1; k < L; k++) begin
         for (int j = 0; j < (HALF >> k); j++) begin
            tree_sum[k][j] <= tree_sum[k-1][2*j] + tree_sum[k-1][2*j+1];
            tree_cnt[k][j] <= tree_cnt[k-1][2*j] + tree_cnt[k-1][2*j+1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_write) begin
         fifo_sum[wr_ptr] <= tree_sum[L-1][0];
         fifo_cnt[wr_ptr] <= tree_cnt[L-1][0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tree_valid <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         occupancy  <= '0;
         slowDown   <= 1'b0;
         batchCount <= '0;
      end else begin
         tree_valid[0] <= launch;
         for (int k = 1; k < L; k++) begin
            tree_valid[k] <= tree_valid[k-1];
         end
         if (fifo_write) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         fifo_level <= fifo_level + OW'(fifo_write) - OW'(pop);
         occupancy  <= occupancy_next;
         slowDown   <= almost_full;
         if (launch) begin
            batchCount <= batchCount + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_result_combiner.sv
// tb/tb_pipeline_result_combiner.sv - scoreboard bench for pipeline_result_combiner
module tb_pipeline_result_combiner;

   localparam int N   = 4;
   localparam int SW  = 48;
   localparam int CW  = 13;
   localparam int FDL = 2;
   localparam int AFM = 1;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   chanValid;
   logic [N*SW-1:0] chanSum;
   logic [N*CW-1:0] chanCount;
   logic [N-1:0]   chanGrab;
   logic           outValid;
   logic [SW+1:0]  outSum;
   logic [CW+1:0]  outCount;
   logic           outGrab;
   logic           slowDown;
   logic [31:0]    batchCount;

   logic [SW-1:0]  vs [N];
   logic [CW-1:0]  vc [N];
   logic [64:0]    exp_q [$];
   logic [64:0]    exp_head;
   int             checks = 0;
   int             passes = 0;

   pipeline_result_combiner #(
      .NUM_CHANNELS(N), .SUM_WIDTH(SW), .COUNT_WIDTH(CW),
      .FIFO_DEPTH_LOG2(FDL), .ALMOST_FULL_MARGIN(AFM)
   ) dut (
      .clk(clk), .rst_n(rst_n), .chanValid(chanValid), .chanSum(chanSum),
      .chanCount(chanCount), .chanGrab(chanGrab), .outValid(outValid),
      .outSum(outSum), .outCount(outCount), .outGrab(outGrab),
      .slowDown(slowDown), .batchCount(batchCount)
   );

   always #5 clk = ~clk;

   always_comb begin
      chanSum   = '0;
      chanCount = '0;
      for (int i = 0; i < N; i++) begin
         chanSum[i*SW +: SW]   = vs[i];
         chanCount[i*CW +: CW] = vc[i];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n && outValid && outGrab) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL out_unexpected: got sum %0h count %0h expected no output", outSum, outCount);
         end else begin
            exp_head = exp_q.pop_front();
            check("out_sum", 64'(outSum), 64'(exp_head[64:15]));
            check("out_count", 64'(outCount), 64'(exp_head[14:0]));
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_vals(input logic [SW-1:0] s0, s1, s2, s3, input logic [CW-1:0] c0, c1, c2, c3);
      vs[0] = s0; vs[1] = s1; vs[2] = s2; vs[3] = s3;
      vc[0] = c0; vc[1] = c1; vc[2] = c2; vc[3] = c3;
   endtask

   task automatic wait_grabs(input logic [N-1:0] mask);
      logic [N-1:0] g;
      bit done = 0;
      chanValid = mask;
      for (int t = 0; t < 100 && !done; t++) begin
         @(negedge clk);
         g = chanGrab & chanValid;
         @(posedge clk);
         #1;
         chanValid = chanValid & ~g;
         if (chanValid == '0) done = 1;
      end
      if (!done) begin
         checks++;
         $display("FAIL grab_timeout: got valid %b still pending expected all grabbed", chanValid);
         chanValid = '0;
      end
   endtask

   task automatic deliver(input logic [SW-1:0] s0, s1, s2, s3, input logic [CW-1:0] c0, c1, c2, c3,
                          input logic [SW+1:0] es, input logic [CW+1:0] ec);
      set_vals(s0, s1, s2, s3, c0, c1, c2, c3);
      exp_q.push_back({es, ec});
      wait_grabs(4'hF);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; chanValid = '0; outGrab = 1'b0;
      set_vals(0, 0, 0, 0, 0, 0, 0, 0);
      cycles(2);
      check("rst_out_valid", 64'(outValid), 0);
      check("rst_slow_down", 64'(slowDown), 0);
      check("rst_batch_count", 64'(batchCount), 0);
      check("rst_out_sum", 64'(outSum), 0);
      check("rst_out_count", 64'(outCount), 0);
      check("rst_chan_grab", 64'(chanGrab), 64'hF);
      rst_n = 1'b1;
      cycles(2);

      // basic batch and latency
      outGrab = 1'b1;
      set_vals(1, 2, 3, 4, 10, 20, 30, 40);
      exp_q.push_back({50'd10, 15'd100});
      chanValid = 4'hF;
      @(negedge clk);
      check("t1_grab_all", 64'(chanGrab), 64'hF);
      @(posedge clk); #1;
      chanValid = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t1_latency", 64'(outValid), 64'(k == 3));
         if (k < 3) @(posedge clk);
      end
      cycles(2);
      check("t1_batch_count", 64'(batchCount), 1);
      check("t1_slow_down", 64'(slowDown), 0);

      // partial batch, last channel late
      set_vals(5, 6, 7, 8, 1, 2, 3, 4);
      exp_q.push_back({50'd26, 15'd10});
      chanValid = 4'b0111;
      @(posedge clk); #1;
      chanValid = '0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t2_grab_held", 64'(chanGrab[2:0]), 0);
         if (k == 4) chanValid = 4'b1000;
         @(posedge clk);
      end
      #1;
      chanValid = '0;
      check("t2_no_early_launch", 64'(batchCount), 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t2_latency", 64'(outValid), 64'(k == 3));
         if (k < 3) @(posedge clk);
      end
      cycles(2);
      check("t2_batch_count", 64'(batchCount), 2);

      // maximum operands
      deliver(48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF,
              13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF, 50'h3_FFFF_FFFF_FFFC, 15'h7FFC);
      cycles(6);
      check("t4_batch_count", 64'(batchCount), 3);

      // backpressure with a 4-entry FIFO
      outGrab = 1'b0;
      deliver(101, 102, 103, 104, 1, 1, 1, 1, 410, 4);
      deliver(201, 202, 203, 204, 2, 2, 2, 2, 810, 8);
      deliver(301, 302, 303, 304, 3, 3, 3, 3, 1210, 12);
      deliver(401, 402, 403, 404, 4, 4, 4, 4, 1610, 16);
      deliver(501, 502, 503, 504, 5, 5, 5, 5, 2010, 20);
      cycles(6);
      check("t3_out_valid", 64'(outValid), 1);
      check("t3_slow_down", 64'(slowDown), 1);
      check("t3_grab_blocked", 64'(chanGrab), 0);
      check("t3_batch_held", 64'(batchCount), 7);
      set_vals(601, 602, 603, 604, 6, 6, 6, 6);
      exp_q.push_back({50'd2410, 15'd24});
      chanValid = 4'hF;
      cycles(3);
      check("t3_grab_still_blocked", 64'(chanGrab), 0);
      check("t3_batch_still_held", 64'(batchCount), 7);
      outGrab = 1'b1;
      cycles(1);
      outGrab = 1'b0;
      wait_grabs(4'hF);
      cycles(6);
      check("t3_one_more_launch", 64'(batchCount), 8);
      check("t3_slow_down_again", 64'(slowDown), 1);
      check("t3_grab_blocked_again", 64'(chanGrab), 0);
      outGrab = 1'b1;
      deliver(701, 702, 703, 704, 7, 7, 7, 7, 2810, 28);
      cycles(20);
      check("t3_drained", 64'(exp_q.size()), 0);
      check("t3_empty", 64'(outValid), 0);
      check("t3_final_batches", 64'(batchCount), 10);

      // asynchronous reset mid-tree
      outGrab = 1'b0;
      deliver(801, 802, 803, 804, 8, 8, 8, 8, 3210, 32);
      deliver(901, 902, 903, 904, 9, 9, 9, 9, 3610, 36);
      cycles(6);
      check("t5_buffered", 64'(outValid), 1);
      deliver(1001, 1002, 1003, 1004, 10, 10, 10, 10, 4010, 40);
      cycles(1);
      rst_n = 1'b0;
      #1;
      check("t5_async_valid", 64'(outValid), 0);
      check("t5_async_batch", 64'(batchCount), 0);
      check("t5_async_sum", 64'(outSum), 0);
      exp_q.delete();
      cycles(1);
      rst_n = 1'b1;
      cycles(1);
      outGrab = 1'b1;
      deliver(11, 22, 33, 44, 1, 2, 3, 4, 110, 10);
      cycles(6);
      check("t5_batch_count", 64'(batchCount), 1);
      check("t5_drained", 64'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
